// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per enabled cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one cycle
// MUL   | shift-add iterations, one multiplier bit per cycle
// DIV   | restoring shift-subtract, one quotient bit per cycle
// FIX   | sign correction, HI/LO write, done pulse
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = 6;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   orig_a;
  logic               neg_q, neg_r, is_div, dbz;

  logic               accept, is_signed, last_iter;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_cand;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    accept    = start && (state == S_IDLE);
    is_signed = ~op[0];
    abs_a     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    abs_b     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_nxt = S_MUL;
            OP_DIV, OP_DIVU:   state_nxt = S_DIV;
            default:           state_nxt = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: if (last_iter) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    div_cand = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_cand >= {1'b0, opnd});
    div_rem  = div_ge ? (div_cand[WIDTH-1:0] - opnd) : div_cand[WIDTH-1:0];
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      orig_a <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (clk_enable) begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= srca;
              OP_MTLO: lo <= srca;
              OP_MULT, OP_MULTU: begin
                acc    <= {{WIDTH{1'b0}}, abs_b};
                opnd   <= abs_a;
                neg_q  <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                is_div <= 1'b0;
                cnt    <= '0;
              end
              OP_DIV, OP_DIVU: begin
                acc    <= {{WIDTH{1'b0}}, abs_a};
                opnd   <= abs_b;
                neg_q  <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                neg_r  <= is_signed & srca[WIDTH-1];
                orig_a <= srca;
                dbz    <= (srcb == '0);
                is_div <= 1'b1;
                cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          acc <= {div_rem, acc[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dbz) begin
            // divide-by-zero returns the untouched dividend rather than the iterated remainder
            hi <= orig_a;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit with a reference model feeding an
// expected-result queue that is drained on each done pulse.
module tb_mips_muldiv_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .op(op), .srca(srca), .srcb(srcb),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] da, db;
    logic [31:0] q, r;
    model = '0;
    case (o)
      3'b000: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        model = sa * sb;
      end
      3'b001: model = {32'h0, a} * {32'h0, b};
      3'b010: begin
        da = a;
        db = b;
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = da / db;
          r = da % db;
          model = {r, q};
        end
      end
      3'b011: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit push);
    op = o; srca = a; srcb = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@accept"}, busy, 1'b1);
    if (push) begin
      exp_q.push_back(model(o, a, b));
      tag_q.push_back(tag);
    end
  endtask

  task automatic wait_result(input int exp_lat, input bit hammer, input int stall_at,
                             input int stall_len, input bit hold_done);
    logic [31:0] old_hi, old_lo;
    logic [63:0] e;
    string t;
    int n;
    bit held;
    old_hi = hi; old_lo = lo; n = 0; held = 1'b1;
    if (hammer) begin
      start = 1'b1; op = 3'b101; srca = 32'h0;
    end
    while (n < 60) begin
      clk_enable = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
      tick();
      n++;
      if (done) break;
      if (hi !== old_hi || lo !== old_lo || busy !== 1'b1) held = 1'b0;
    end
    clk_enable = 1'b1;
    start = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
    end else begin
      e = 'x;
      t = "orphan";
    end
    check({t, " latency"}, n, exp_lat);
    check({t, " hold"}, held, 1'b1);
    check({t, " hi"}, hi, e[63:32]);
    check({t, " lo"}, lo, e[31:0]);
    check({t, " busy@done"}, busy, 1'b0);
    if (hold_done) begin
      clk_enable = 1'b0;
      tick();
      check({t, " done frozen"}, done, 1'b1);
      clk_enable = 1'b1;
    end
    tick();
    check({t, " done fall"}, done, 1'b0);
    if (hammer) check({t, " mtlo ignored"}, lo, e[31:0]);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
    op = 3'b110; srca = '0; srcb = '0;
    #2 reset = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, "mult -3*5", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    check("mult const hi", hi, 32'hFFFF_FFFF);
    check("mult const lo", lo, 32'hFFFF_FFF1);

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);

    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, "div -7/2", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    issue(3'b011, 32'd100, 32'd7, "divu 100/7", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    check("divu const lo", lo, 32'd14);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    issue(3'b011, 32'd5, 32'd0, "divu by0", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, "div by0", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);
    issue(3'b010, 32'd1000, 32'hFFFF_FFFD, "div 1000/-3", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);

    op = 3'b100; srca = 32'h1234_5678; start = 1'b1;
    tick();
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi busy", busy, 1'b0);
    check("mthi done", done, 1'b0);
    op = 3'b101; srca = 32'h9ABC_DEF0;
    tick();
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi kept", hi, 32'h1234_5678);
    check("mtlo busy", busy, 1'b0);
    op = 3'b110; srca = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("nop hi", hi, 32'h1234_5678);
    check("nop lo", lo, 32'h9ABC_DEF0);
    check("nop busy", busy, 1'b0);
    check("nop done", done, 1'b0);

    issue(3'b000, 32'h0000_1234, 32'h0000_5678, "mult hammer", 1'b1);
    wait_result(33, 1'b1, 0, 0, 1'b0);

    issue(3'b000, 32'hFFFF_0001, 32'h7FFF_FFFF, "mult stall", 1'b1);
    wait_result(38, 1'b0, 10, 5, 1'b1);

    issue(3'b011, 32'hCAFE_F00D, 32'd3, "divu reset", 1'b0);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    issue(3'b000, 32'd7, 32'hFFFF_FFFA, "mult after rst", 1'b1);
    wait_result(33, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Sits directly downstream of the instruction decoder and register-file read ports.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO, and a busy flag so the fetch stage can stall.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- clk_enable  input  1  global advance enable; when low, all state freezes.
- start  input  1  request to issue op this cycle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- srca  input  WIDTH  rs value; dividend, multiplicand, or MTHI/MTLO source.
- srcb  input  WIDTH  rt value; divisor or multiplier.
- busy  output  1  high while a multiply/divide is in progress.
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Takes effect immediately, including mid-operation; the partial result is discarded.
- Accept condition: start=1, busy=0, clk_enable=1 at a rising edge. When busy=1, start is ignored entirely (op not queued, HI/LO untouched).
- clk_enable=0: no state, counter, HI/LO or done change. A done pulse already high stays high until the next enabled edge.
- MTHI/MTLO: hi (or lo) <= srca at the accept edge. busy stays 0 and done is not asserted. The other register is unchanged.
- Op 110/111: no effect.
- MULT/MULTU/DIV/DIVU: accept at edge k.
  - Latch |srca| and |srcb| (signed ops) or the raw values (unsigned ops), plus the result-sign flags.
  - State -> MUL or DIV; busy=1 from edge k.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per enabled cycle, 32 iterations (edges k+1..k+32).
- DIV: restoring shift-subtract, one quotient bit per enabled cycle, 32 iterations.
- FIX state, at edge k+33:
  - Apply sign correction and write hi/lo.
  - busy falls to 0 and done rises to 1 at this edge; done falls at edge k+34.
  - State -> IDLE.
  - Total latency is 33 enabled cycles from accept to visible result.
  - A new start can be accepted at edge k+34.
- hi/lo hold their previous values throughout busy. There is no partial-result visibility.
- Signed multiply: 64-bit two's-complement product; HI = bits 63:32, LO = bits 31:0.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=srca as latched (original signed value). Same 33-cycle latency, done asserted.
- Counter is 6 bits; compare against WIDTH, no wrap-around.

Test Plan:
- Reset, then MULT srca=0xFFFFFFFD, srcb=0x00000005 -> busy high for 33 cycles; done pulse at accept+33; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Also check hi/lo keep old values while busy.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 100/7 -> LO=14, HI=2. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU srca=5, srcb=0 -> after 33 cycles LO=0xFFFFFFFF, HI=5, done pulses once.
- MTHI srca=0x12345678 then MTLO srca=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each accept edge; busy and done never assert. Then start MULT and, while busy, issue MTLO 0 -> ignored; lo equals the product at completion.
- Start DIVU, drop reset to 0 at accept+10 -> busy=0, done=0, hi=lo=0 immediately. Also hold clk_enable low for 5 cycles mid-MULT -> completion delayed by exactly 5 cycles with the correct product.
